// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem reader and a 2-entry {instr, pc} queue to decode.
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky fetch_fault and park in FAULT.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  fd_valid,
    input  logic                  fd_ready,
    output logic [DATA_WIDTH-1:0] fd_instruction,
    output logic [DATA_WIDTH-1:0] fd_pc,
    output logic                  fetch_fault,
    output logic [1:0]            dbg_state
);

    // Handshakes (imem request and fetch->decode): a transfer happens in a cycle where valid && ready
    // are both high at the rising edge; valid never depends on ready, and payload holds while valid && !ready.

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
        , ST_FAULT = 2'd3
`endif
    } state_e;

    state_e                state_q, state_d, resume_state;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] s0_instr_q, s0_instr_d, s0_pc_q, s0_pc_d;
    logic [DATA_WIDTH-1:0] s1_instr_q, s1_instr_d, s1_pc_q, s1_pc_d;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  req_fire, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic redirect_misaligned;

    assign redirect_target     = redirect_pc;
    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;
    assign fetch_fault         = fault_q;
`else
    assign redirect_target = redirect_pc & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
    assign fetch_fault     = 1'b0;
`endif

    // count never exceeds 2, so bit 1 set means full; gating here keeps a slot free for the response
    assign imem_req_valid = rst_n && (state_q == ST_REQ) && !count_q[1];
    assign imem_req_addr  = pc_q;
    assign fd_valid       = count_q != 2'd0;
    assign fd_instruction = s0_instr_q;
    assign fd_pc          = s0_pc_q;
    assign dbg_state      = state_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign push     = (state_q == ST_WAIT) && imem_rsp_valid;
    assign pop      = fd_valid && fd_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        s0_instr_d   = s0_instr_q;
        s0_pc_d      = s0_pc_q;
        s1_instr_d   = s1_instr_q;
        s1_pc_d      = s1_pc_q;
        resume_state = ST_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = redirect_misaligned;
        end
        if (fault_d) begin
            resume_state = ST_FAULT;
        end
`endif

        if (redirect_valid) begin
            // Flush wins over any same-cycle push or pop; a still-outstanding response is absorbed in DROP
            count_d = 2'd0;
            pc_d    = redirect_target;
            case (state_q)
                ST_REQ:           state_d = req_fire ? ST_DROP : resume_state;
                ST_WAIT, ST_DROP: state_d = imem_rsp_valid ? resume_state : ST_DROP;
                default:          state_d = resume_state;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = ST_REQ;
                        pc_d    = pc_q + DATA_WIDTH'(4);
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) begin
                        state_d = resume_state;
                    end
                end
                default: ;
            endcase

            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        s0_instr_d = imem_rsp_data;
                        s0_pc_d    = pc_q;
                    end else begin
                        s1_instr_d = imem_rsp_data;
                        s1_pc_d    = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    s0_instr_d = s1_instr_q;
                    s0_pc_d    = s1_pc_q;
                    count_d    = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        s0_instr_d = imem_rsp_data;
                        s0_pc_d    = pc_q;
                    end else begin
                        s0_instr_d = s1_instr_q;
                        s0_pc_d    = s1_pc_q;
                        s1_instr_d = imem_rsp_data;
                        s1_pc_d    = pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            s0_instr_q <= '0;
            s0_pc_q    <= '0;
            s1_instr_q <= '0;
            s1_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            s0_instr_q <= s0_instr_d;
            s0_pc_q    <= s0_pc_d;
            s1_instr_q <= s1_instr_d;
            s1_pc_q    <= s1_pc_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect stimulus against an in-order PC-stream model.
module tb_fetch_unit;
  localparam int W = 32;
  localparam logic [W-1:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [W-1:0] imem_req_addr, imem_rsp_data;
  logic redirect_valid;
  logic [W-1:0] redirect_pc;
  logic fd_valid, fd_ready, fetch_fault;
  logic [W-1:0] fd_instruction, fd_pc;
  logic [1:0] dbg_state;

  fetch_unit #(.DATA_WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_instruction(fd_instruction), .fd_pc(fd_pc),
    .fetch_fault(fetch_fault), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int ready_pct = 100;
  int fd_ready_pct = 100;
  int lat_min = 0;
  int lat_max = 0;
  logic [63:0] exp_q[$];
  logic [W-1:0] fill_pc;
  bit fill_en;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit is_fault_target(input logic [W-1:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] aligned(input logic [W-1:0] t);
    return t & ~32'h3;
  endfunction

  // Decode must see an unbroken +4 stream starting at the last redirect / reset target.
  function automatic void refill();
    if (fill_en) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back({fill_pc, mem_word(fill_pc)});
        fill_pc = fill_pc + 32'd4;
      end
    end
  endfunction

  function automatic void issue_redirect(input logic [W-1:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    exp_q.delete();
    fill_en = !is_fault_target(t);
    fill_pc = aligned(t);
    refill();
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_redirect(input logic [W-1:0] t);
    @(posedge clk); #1;
    issue_redirect(t);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    fill_en = 1'b1;
    fill_pc = RESET_PC;
    refill();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Instruction memory: one response per accepted request after a random delay.
  bit mem_fire, mem_rsp_now, mem_pending;
  logic [W-1:0] mem_addr_s, mem_addr;
  int mem_wait;
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    mem_pending = 1'b0;
    mem_wait = 0;
    forever begin
      @(negedge clk); #1;
      mem_fire = imem_req_valid && imem_req_ready;
      mem_addr_s = imem_req_addr;
      mem_rsp_now = imem_rsp_valid;
      @(posedge clk); #1;
      if (mem_rsp_now) mem_pending = 1'b0;
      if (mem_fire) begin
        mem_pending = 1'b1;
        mem_addr = mem_addr_s;
        mem_wait = $urandom_range(lat_max, lat_min);
      end
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
      if (mem_pending && mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem_word(mem_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        if (mem_pending) mem_wait--;
      end
    end
  end

  initial begin
    fd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      fd_ready = ($urandom_range(99, 0) < fd_ready_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_redirect, req_arm, hold_v;
  logic [W-1:0] req_target, hold_pc, hold_instr;
  logic [63:0] mon_e;
  initial begin
    prev_redirect = 1'b0;
    req_arm = 1'b0;
    hold_v = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        check("req_valid_in_reset", imem_req_valid, 1'b0);
        prev_redirect = 1'b0;
        req_arm = 1'b0;
        hold_v = 1'b0;
      end else begin
        if (prev_redirect) check("flush_fd_valid", fd_valid, 1'b0);
        if (req_arm && imem_req_valid) begin
          check("redirect_req_addr", imem_req_addr, req_target);
          req_arm = 1'b0;
        end
        if (hold_v) begin
          check("hold_pc", fd_pc, hold_pc);
          check("hold_instr", fd_instruction, hold_instr);
        end
        if (fd_valid && fd_ready && !redirect_valid) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc %0h expected no transfer", fd_pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("fd_pc", fd_pc, mon_e[63:32]);
            check("fd_instr", fd_instruction, mon_e[31:0]);
          end
        end
        hold_v = fd_valid && !fd_ready && !redirect_valid;
        hold_pc = fd_pc;
        hold_instr = fd_instruction;
        prev_redirect = redirect_valid;
        if (redirect_valid && !is_fault_target(redirect_pc)) begin
          req_arm = 1'b1;
          req_target = aligned(redirect_pc);
        end
        refill();
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int p0, cnt;
  bit found;
  logic [63:0] head_e;
  logic [W-1:0] rt;
  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fill_en = 1'b1;
    fill_pc = RESET_PC;
    refill();

    // Reset values and first request
    repeat (3) @(negedge clk);
    #1;
    check("reset_fd_valid", fd_valid, 1'b0);
    check("reset_fd_pc", fd_pc, 32'h0);
    check("reset_fd_instr", fd_instruction, 32'h0);
    check("reset_fetch_fault", fetch_fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, RESET_PC);

    // Peak throughput with a 1-cycle memory: one instruction every 2 cycles
    repeat (6) @(negedge clk);
    #2;
    p0 = pops;
    repeat (20) @(negedge clk);
    #2;
    check("throughput_20cyc", pops - p0, 10);

    // Decode stall: two entries queued, no third request, head holds
    fd_ready_pct = 0;
    @(posedge clk); #2;
    p0 = pops;
    repeat (10) @(negedge clk);
    #2;
    check("stall_no_pop", pops - p0, 0);
    check("stall_no_third_req", imem_req_valid, 1'b0);
    check("stall_fd_valid", fd_valid, 1'b1);
    head_e = exp_q[0];
    check("stall_head_pc", fd_pc, head_e[63:32]);
    fd_ready_pct = 100;
    repeat (20) @(negedge clk);

    // Redirect while waiting on a slow response: the stale word must never reach decode
    lat_min = 2;
    lat_max = 2;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk); #2;
      if (imem_req_valid && imem_req_ready) found = 1'b1;
    end
    check("wait_state_reached", found, 1'b1);
    do_redirect(32'h0000_0100);
    repeat (25) @(negedge clk);

    // Redirect coinciding with a response and a pop
    lat_min = 1;
    lat_max = 1;
    fd_ready_pct = 0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (imem_rsp_valid && fd_valid) begin
        found = 1'b1;
        fd_ready_pct = 100;
        fd_ready = 1'b1;
        issue_redirect(32'h0000_0340);
      end
    end
    check("collision_reached", found, 1'b1);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk); #2;
    check("collision_fd_valid", fd_valid, 1'b0);
    repeat (20) @(negedge clk);

    // PC wrap at the top of the address space
    lat_min = 0;
    lat_max = 0;
    do_redirect(32'hFFFF_FFF8);
    repeat (20) @(negedge clk);

    // Misaligned redirect
    do_redirect(32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk); #2;
    check("fault_set", fetch_fault, 1'b1);
    cnt = 0;
    p0 = pops;
    repeat (20) begin
      @(negedge clk); #2;
      if (imem_req_valid) cnt++;
    end
    check("fault_no_requests", cnt, 0);
    check("fault_no_pops", pops - p0, 0);
    check("fault_sticky", fetch_fault, 1'b1);
    do_redirect(32'h0000_0200);
    @(negedge clk); #2;
    check("fault_cleared", fetch_fault, 1'b0);
    p0 = pops;
    repeat (20) @(negedge clk);
    #2;
    check("fault_resume_pops", pops - p0 > 0, 1'b1);
`else
    repeat (20) @(negedge clk);
    #2;
    check("no_fault_flag", fetch_fault, 1'b0);
`endif

    // Randomized traffic with occasional redirects and one mid-run reset
    ready_pct = 70;
    fd_ready_pct = 60;
    lat_min = 0;
    lat_max = 3;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset();
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      if ($urandom_range(99, 0) < 3) begin
        rt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
        rt = aligned(rt);
`endif
        issue_redirect(rt);
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("random_progress", pops - p0 > 100, 1'b1);

    $display("Final fetch state code %0d after %0d decode transfers", dbg_state, pops);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
